// File: rtl/seg7_scan_driver.sv
// Five-digit common-anode 7-segment scanner: latches BCD digits on load and
// time-multiplexes them with leading-zero blanking and an anti-ghosting guard.
module seg7_scan_driver #(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned GUARD       = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] bcd_1,
   input  logic [3:0] bcd_10,
   input  logic [3:0] bcd_100,
   input  logic [3:0] bcd_1000,
   input  logic [3:0] bcd_10000,
   input  logic       blank_lz,
   output logic [4:0] an,
   output logic [6:0] seg,
   output logic       frame_done
);

   localparam int unsigned CW = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [3:0]    dig_q [5];
   logic [3:0]    dig_d [5];
   logic [3:0]    bcd_in [5];
   logic [4:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          frame_done_q, frame_done_d;
   logic [4:0]    blank;
   logic          zero_run;
   logic [3:0]    cur_dig;

   assign bcd_in[0] = bcd_1;
   assign bcd_in[1] = bcd_10;
   assign bcd_in[2] = bcd_100;
   assign bcd_in[3] = bcd_1000;
   assign bcd_in[4] = bcd_10000;

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   generate
      for (genvar gi = 0; gi < 5; gi++) begin : g_latch
         assign dig_d[gi] = load ? bcd_in[gi] : dig_q[gi];
      end
   endgenerate

   // A digit is blanked only while it and every digit above it are zero.
   always_comb begin
      blank    = 5'b00000;
      zero_run = 1'b1;
      for (int k = 4; k >= 1; k--) begin
         zero_run = zero_run && (dig_q[k] == 4'd0);
         blank[k] = blank_lz && zero_run;
      end
   end

   assign cur_dig = dig_q[idx_q];

   always_comb begin
      cnt_d        = cnt_q + 1'b1;
      idx_d        = idx_q;
      frame_done_d = 1'b0;
      an_d         = 5'b11111;
      seg_d        = 7'b1111111;
      if (cnt_q == CNT_MAX) begin
         cnt_d        = '0;
         idx_d        = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
         frame_done_d = (idx_q == 3'd4);
      end
      if (!(cnt_q < GUARD_C)) begin
         an_d  = ~(5'b00001 << idx_q);
         seg_d = blank[idx_q] ? 7'b1111111 : decode(cur_dig);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         idx_q        <= 3'd0;
         an_q         <= 5'b11111;
         seg_q        <= 7'b1111111;
         frame_done_q <= 1'b0;
         for (int k = 0; k < 5; k++) dig_q[k] <= 4'd0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         frame_done_q <= frame_done_d;
         for (int k = 0; k < 5; k++) dig_q[k] <= dig_d[k];
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized and directed bench for seg7_scan_driver against a time-index
// reference model (digit period and position derived from elapsed cycles).
module tb_seg7_scan_driver;

   localparam int R = 8;
   localparam int G = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load = 1'b0;
   logic [3:0] bcd_1 = 4'd0, bcd_10 = 4'd0, bcd_100 = 4'd0, bcd_1000 = 4'd0, bcd_10000 = 4'd0;
   logic       blank_lz = 1'b0;
   logic [4:0] an;
   logic [6:0] seg;
   logic       frame_done;

   seg7_scan_driver #(.REFRESH_DIV(R), .GUARD(G)) dut (
      .clk(clk), .rst(rst), .load(load),
      .bcd_1(bcd_1), .bcd_10(bcd_10), .bcd_100(bcd_100),
      .bcd_1000(bcd_1000), .bcd_10000(bcd_10000),
      .blank_lz(blank_lz), .an(an), .seg(seg), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_errors = 0;
   int         t = 0;
   logic [3:0] md [5];
   logic [6:0] seg_tab [16];
   logic [4:0] obs_an;
   logic [6:0] obs_seg;
   logic       obs_fd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // One clock: drive inputs, predict the registered outputs, advance the model, compare.
   task automatic step(input bit r, input bit ld, input logic [19:0] dv, input bit blz);
      logic [4:0] e_an;
      logic [6:0] e_seg;
      logic       e_fd;
      int         c, i, hi;
      rst = r; load = ld; blank_lz = blz;
      bcd_1 = dv[3:0]; bcd_10 = dv[7:4]; bcd_100 = dv[11:8];
      bcd_1000 = dv[15:12]; bcd_10000 = dv[19:16];
      e_an = 5'b11111; e_seg = 7'b1111111; e_fd = 1'b0;
      if (r) begin
         for (int k = 0; k < 5; k++) md[k] = 4'd0;
         t = 0;
      end else begin
         c = t % R;
         i = (t / R) % 5;
         hi = -1;
         for (int k = 0; k < 5; k++) if (md[k] != 4'd0) hi = k;
         if (c >= G) begin
            e_an  = ~(5'(1) << i);
            e_seg = (blz && i >= 1 && i > hi) ? 7'b1111111 : seg_tab[md[i]];
         end
         e_fd = ((t % (5 * R)) == 5 * R - 1);
         if (ld) for (int k = 0; k < 5; k++) md[k] = dv[4*k +: 4];
         t++;
      end
      @(posedge clk);
      #1;
      obs_an = an; obs_seg = seg; obs_fd = frame_done;
      $display("t=%0d rst=%0b load=%0b blz=%0b an=%b seg=%b fd=%0b", t, r, ld, blz, an, seg, frame_done);
      chk("an", 32'(an), 32'(e_an));
      chk("seg", 32'(seg), 32'(e_seg));
      chk("frame_done", 32'(frame_done), 32'(e_fd));
   endtask

   initial begin
      logic [6:0] seen [5];
      int         cnt_a, fd_cnt, pos;
      logic [19:0] dv;
      bit          blz;
      seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
      seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
      seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
      seg_tab[9] = 7'b0010000;
      for (int k = 10; k < 16; k++) seg_tab[k] = 7'b0111111;

      // Reset and idle
      step(1, 0, 20'h0, 1);
      step(1, 0, 20'h0, 1);
      cnt_a = 0;
      for (int n = 0; n < 40; n++) begin
         step(0, 0, 20'hFFFFF, 1);
         if (obs_an == 5'b11110 && obs_seg == 7'b1000000) cnt_a++;
      end
      chk("idle_ones_cycles", 32'(cnt_a), 32'(R - G));

      // Full value, no blanking
      step(0, 1, 20'h16024, 0);
      fd_cnt = 0;
      for (int k = 0; k < 5; k++) seen[k] = 7'h00;
      for (int n = 0; n < 40; n++) begin
         step(0, 0, 20'h0, 0);
         fd_cnt += int'(obs_fd);
         for (int k = 0; k < 5; k++) if (obs_an == ~(5'(1) << k)) seen[k] = obs_seg;
      end
      chk("full_d0", 32'(seen[0]), 32'(7'b0011001));
      chk("full_d1", 32'(seen[1]), 32'(7'b0100100));
      chk("full_d2", 32'(seen[2]), 32'(7'b1000000));
      chk("full_d3", 32'(seen[3]), 32'(7'b0000010));
      chk("full_d4", 32'(seen[4]), 32'(7'b1111001));
      chk("frame_pulses", 32'(fd_cnt), 32'd1);

      // Leading-zero blanking, then blanking off
      step(0, 1, 20'h00307, 1);
      for (int n = 0; n < 45; n++) step(0, 0, 20'h0, 1);
      for (int n = 0; n < 45; n++) step(0, 0, 20'h0, 0);

      // Non-BCD tens digit
      step(0, 1, 20'h000C0, 1);
      for (int n = 0; n < 45; n++) step(0, 0, 20'h0, 1);

      // Load mid-scan at cnt=4 of digit 0
      step(0, 1, 20'h00001, 1);
      while ((t % (5 * R)) != 4) step(0, 0, 20'h0, 1);
      step(0, 1, 20'h00005, 1);
      chk("midload_old", 32'(obs_seg), 32'(7'b1111001));
      step(0, 0, 20'h0, 1);
      chk("midload_new", 32'(obs_seg), 32'(7'b0010010));
      for (int n = 0; n < 40; n++) step(0, 0, 20'h0, 1);

      // Reset mid-frame at idx=3
      step(0, 1, 20'h98765, 0);
      while (((t / R) % 5) != 3) step(0, 0, 20'h0, 0);
      step(1, 0, 20'h0, 0);
      chk("rst_an", 32'(obs_an), 32'(5'b11111));
      chk("rst_seg", 32'(obs_seg), 32'(7'b1111111));
      for (int n = 0; n < 40; n++) step(0, 0, 20'h0, 0);

      // Random traffic
      blz = 1'b1;
      for (int n = 0; n < 1500; n++) begin
         for (int k = 0; k < 5; k++)
            dv[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         if ($urandom_range(0, 63) == 0) blz = ~blz;
         step(($urandom_range(0, 399) == 0), ($urandom_range(0, 15) == 0), dv, blz);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
